axi_master: RTL and testbench

Parallel-to-stream serializer that accepts one 64-bit word from a local write port and transmits it as eight bytes on an AXI-Stream-style master interface (data/valid/ready/last). Byte 0 (bits [7:0]) goes first, byte 7 (bits [63:56]) goes last and carries `last`. The block sits between a register/host-side producer and any AXI-Stream byte sink. It holds one word at a time and accepts no new word while a transfer is in progress.

---
 rtl/axi_master.sv | 86 ++++++++
 tb/tb_axi_master.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/axi_master.sv
// -----------------------------------------------------------------------------
// axi_master
//
// Parallel-to-stream serializer. A word of NBYTES beats is loaded from a local
// write port. It is then sent one BYTE_W-bit beat at a time on an
// AXI-Stream-style master port. Beat 0 (the low bits) goes first. The final
// beat carries `last`. Only one word is held at a time, and `we` is ignored
// while a transfer is in progress.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. While valid=1 and ready=0, data and last hold steady. valid never
// depends combinationally on ready. ready may be high while idle; it has no
// effect then.
//
// Ports:
//   clk      in   clock, all state changes on its rising edge
//   reset_n  in   asynchronous active-low reset
//   data_in  in   [BYTE_W*NBYTES-1:0] word to serialize, byte k sent k-th
//   we       in   load strobe, honoured only while idle
//   data     out  [BYTE_W-1:0] current beat (low byte of the shift buffer)
//   valid    out  beat available
//   last     out  current beat is the final beat of the word
//   ready    in   sink accepts the beat
// -----------------------------------------------------------------------------
module axi_master #(
   parameter int BYTE_W = 8,
   parameter int NBYTES = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [BYTE_W*NBYTES-1:0] data_in,
   input  logic                     we,
   output logic [BYTE_W-1:0]        data,
   output logic                     valid,
   output logic                     last,
   input  logic                     ready
);

   localparam int WORD_W = BYTE_W * NBYTES;
   localparam int CNT_W  = $clog2(NBYTES + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBYTES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   // buff_count is the number of beats remaining. Zero means idle.
   logic [WORD_W-1:0] data_buff, data_buff_nxt;
   logic [CNT_W-1:0]  buff_count, buff_count_nxt;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_buff  <= '0;
         buff_count <= CNT_ZERO;
      end else begin
         data_buff  <= data_buff_nxt;
         buff_count <= buff_count_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      data_buff_nxt  = data_buff;
      buff_count_nxt = buff_count;
      if (buff_count == CNT_ZERO) begin
         if (we) begin
            data_buff_nxt  = data_in;
            buff_count_nxt = CNT_FULL;
         end
      end else if (ready) begin
         // The zero-fill from the top leaves the buffer at 0 once the final
         // beat has gone out. As a result, data reads 0 whenever the block is
         // idle.
         data_buff_nxt  = data_buff >> BYTE_W;
         buff_count_nxt = buff_count - CNT_ONE;
      end
   end

   // Outputs come from registers only
   always_comb begin
      valid = (buff_count != CNT_ZERO);
      last  = (buff_count == CNT_ONE);
      data  = data_buff[BYTE_W-1:0];
   end

endmodule

// File: tb/tb_axi_master.sv
// -----------------------------------------------------------------------------
// tb_axi_master
//
// Directed and randomized stimulus for axi_master. The reference model is a
// queue of the bytes still owed to the sink:
//   - a load while the queue is empty pushes all eight bytes;
//   - a cycle with ready while the queue is non-empty pops one byte;
//   - valid means "queue non-empty";
//   - last means "exactly one byte left";
//   - data is the queue head, or 0 when the queue is empty.
// -----------------------------------------------------------------------------
module tb_axi_master;

   logic        clk;
   logic        reset_n;
   logic [63:0] data_in;
   logic        we;
   logic [7:0]  data;
   logic        valid;
   logic        last;
   logic        ready;

   logic [7:0]  exp_q[$];
   int          n_checks;
   int          n_pass;

   axi_master #(.BYTE_W(8), .NBYTES(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .data_in (data_in),
      .we      (we),
      .data    (data),
      .valid   (valid),
      .last    (last),
      .ready   (ready)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   // Compare outputs against the model, apply inputs, advance the model across
   // the coming edge, then move to 1 time unit after that edge.
   task automatic cycle(input logic w, input logic [63:0] din, input logic r);
      we      = w;
      data_in = din;
      ready   = r;
      check("valid", valid, (exp_q.size() != 0));
      check("last",  last,  (exp_q.size() == 1));
      check("data",  data,  (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      check("count", dut.buff_count, exp_q.size());
      if (exp_q.size() == 0) begin
         if (w) for (int k = 0; k < 8; k++) exp_q.push_back(din[8*k +: 8]);
      end else if (r) begin
         void'(exp_q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input logic r);
      for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, r);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      we       = 1'b0;
      ready    = 1'b0;
      data_in  = 64'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", valid, 1'b0);
      check("rst_last",  last,  1'b0);
      check("rst_data",  data,  8'h00);
      check("rst_count", dut.buff_count, 0);
      reset_n = 1'b1;
      run(2, 1'b1);

      // Full word, ready held high
      cycle(1'b1, 64'hF0DEBC9A78563412, 1'b1);
      run(10, 1'b1);

      // Stall of 5 cycles after 3 beats
      cycle(1'b1, 64'h8877665544332211, 1'b1);
      run(3, 1'b1);
      run(5, 1'b0);
      run(7, 1'b1);

      // Zero upper bytes are still sent
      cycle(1'b1, 64'h00000000D4C3B2A1, 1'b1);
      run(9, 1'b1);

      // Load attempt mid-transfer is ignored
      cycle(1'b1, 64'h8877665544332211, 1'b1);
      run(2, 1'b1);
      cycle(1'b1, 64'hFFEEDDCCBBAA9988, 1'b1);
      run(10, 1'b1);

      // Load attempt on the final handshake edge is ignored
      cycle(1'b1, 64'h0123456789ABCDEF, 1'b1);
      run(7, 1'b1);
      cycle(1'b1, 64'hDEADBEEFCAFEF00D, 1'b1);
      run(3, 1'b1);

      // Asynchronous reset mid-transfer
      cycle(1'b1, 64'h1122334455667788, 1'b1);
      run(3, 1'b1);
      reset_n = 1'b0;
      #1;
      check("arst_valid", valid, 1'b0);
      check("arst_last",  last,  1'b0);
      check("arst_data",  data,  8'h00);
      check("arst_count", dut.buff_count, 0);
      check("arst_buff",  dut.data_buff, 64'h0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      run(3, 1'b1);

      // Long stall right after load
      cycle(1'b1, 64'hA5A5_5A5A_C3C3_3C3C, 1'b1);
      run(10, 1'b0);
      run(9, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) == 0), {$urandom(), $urandom()}, ($urandom_range(0, 3) != 0));
      end
      run(40, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
